// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
// Width codes, FSM state and owner encodings, default address width.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [2:0] WID_1 = 3'd1;
  localparam logic [2:0] WID_2 = 3'd2;
  localparam logic [2:0] WID_4 = 3'd4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  // Any width code other than 1 or 2 is a full word.
  function automatic logic [2:0] wid_dec(input logic [2:0] w);
    case (w)
      WID_1, WID_2: wid_dec = w;
      default:      wid_dec = WID_4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/completion bundle for IF and LSB plus the byte-wide RAM port.
// The arbiter takes the slave view; requesters and RAM take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W_DEF
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;

  logic              ls_req_i;
  logic              ls_rw_i;
  logic [2:0]        ls_wid_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [31:0]       ls_wdata_i;
  logic              ls_done_o;
  logic [31:0]       ls_rdata_o;

  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic [7:0]        mem_din_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_done_o, if_data_o,
    input  ls_req_i, ls_rw_i, ls_wid_i,
    input  ls_addr_i, ls_wdata_i,
    output ls_done_o, ls_rdata_o,
    output mem_a_o, mem_dout_o, mem_wr_o,
    input  mem_din_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_done_o, if_data_o,
    output ls_req_i, ls_rw_i, ls_wid_i,
    output ls_addr_i, ls_wdata_i,
    input  ls_done_o, ls_rdata_o,
    input  mem_a_o, mem_dout_o, mem_wr_o,
    output mem_din_i
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way requester pick; LSB first, or round-robin under MEM_ARB_RR_EN.
module mem_arb_pick (
  input  logic if_req,
  input  logic ls_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_ls,
`endif
  output logic gnt_if,
  output logic gnt_ls
);

  logic ls_first;
  logic ls_win;
  logic if_win;

`ifdef MEM_ARB_RR_EN
  assign ls_first = !last_ls;
`else
  assign ls_first = 1'b1;
`endif

  assign ls_win = ls_req && (ls_first || !if_req);
  assign if_win = if_req && !ls_win;

  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    unique case (1'b1)
      ls_win:  gnt_ls = 1'b1;
      if_win:  gnt_if = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and the load/store buffer.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of LSB-first.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clr_i,
  mem_arbiter_if.slave bus
);

  state_t            state, state_n;
  owner_t            owner, owner_n;
  logic [2:0]        k, k_n;
  logic [2:0]        wid, wid_n;
  logic [2:0]        km1;
  logic              rw, rw_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [31:0]       wdata, wdata_n;
  logic [31:0]       rbuf, rbuf_n, rcap;
  logic [31:0]       if_data, if_data_n;
  logic [31:0]       ls_data, ls_data_n;
  logic              if_done, if_done_n;
  logic              ls_done, ls_done_n;
  logic              gnt_if, gnt_ls;
  logic              drive;
`ifdef MEM_ARB_RR_EN
  logic              last_ls, last_ls_n;
`endif

  // A requester still seeing its done pulse is holding a stale req.
  mem_arb_pick u_pick (
    .if_req  (bus.if_req_i && !if_done),
    .ls_req  (bus.ls_req_i && !ls_done),
`ifdef MEM_ARB_RR_EN
    .last_ls (last_ls),
`endif
    .gnt_if  (gnt_if),
    .gnt_ls  (gnt_ls)
  );

  assign drive = (state == S_BUSY) && (k < wid);
  assign km1   = k - 3'd1;
  assign rcap  = rbuf | (32'(bus.mem_din_i) << {km1[1:0], 3'b000});

  assign bus.mem_a_o    = drive ? base + ADDR_W'(k) : '0;
  assign bus.mem_wr_o   = drive && rw && rdy;
  assign bus.mem_dout_o = (drive && rw) ? wdata[{k[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.if_done_o  = if_done;
  assign bus.if_data_o  = if_data;
  assign bus.ls_done_o  = ls_done;
  assign bus.ls_rdata_o = ls_data;

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    k_n       = k;
    wid_n     = wid;
    rw_n      = rw;
    base_n    = base;
    wdata_n   = wdata;
    rbuf_n    = rbuf;
    if_data_n = if_data;
    ls_data_n = ls_data;
    if_done_n = 1'b0;
    ls_done_n = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_ls_n = last_ls;
`endif
    unique case (state)
      S_IDLE: begin
        if (!clr_i && (gnt_if || gnt_ls)) begin
          state_n = S_BUSY;
          k_n     = 3'd0;
          rbuf_n  = '0;
`ifdef MEM_ARB_RR_EN
          last_ls_n = gnt_ls;
`endif
          if (gnt_ls) begin
            owner_n = OWN_LS;
            base_n  = bus.ls_addr_i;
            wid_n   = wid_dec(bus.ls_wid_i);
            rw_n    = bus.ls_rw_i;
            wdata_n = bus.ls_wdata_i;
          end else begin
            owner_n = OWN_IF;
            base_n  = bus.if_addr_i;
            wid_n   = WID_4;
            rw_n    = 1'b0;
            wdata_n = '0;
          end
        end
      end
      S_BUSY: begin
        if (rw) begin
          // Stores are committed; a flush never cuts them short.
          if (k == wid - 3'd1) begin
            state_n   = S_IDLE;
            owner_n   = OWN_NONE;
            k_n       = 3'd0;
            ls_done_n = 1'b1;
          end else begin
            k_n = k + 3'd1;
          end
        end else if (clr_i) begin
          state_n = S_IDLE;
          owner_n = OWN_NONE;
          k_n     = 3'd0;
        end else begin
          if (k != 3'd0) rbuf_n = rcap;
          if (k == wid) begin
            state_n = S_IDLE;
            owner_n = OWN_NONE;
            k_n     = 3'd0;
            if (owner == OWN_IF) begin
              if_done_n = 1'b1;
              if_data_n = rcap;
            end else begin
              ls_done_n = 1'b1;
              ls_data_n = rcap;
            end
          end else begin
            k_n = k + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      owner   <= OWN_NONE;
      k       <= 3'd0;
      wid     <= 3'd0;
      rw      <= 1'b0;
      base    <= '0;
      wdata   <= '0;
      rbuf    <= '0;
      if_data <= '0;
      ls_data <= '0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ls <= 1'b0;
`endif
    end else if (rdy) begin
      state   <= state_n;
      owner   <= owner_n;
      k       <= k_n;
      wid     <= wid_n;
      rw      <= rw_n;
      base    <= base_n;
      wdata   <= wdata_n;
      rbuf    <= rbuf_n;
      if_data <= if_data_n;
      ls_data <= ls_data_n;
      if_done <= if_done_n;
      ls_done <= ls_done_n;
`ifdef MEM_ARB_RR_EN
      last_ls <= last_ls_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model on the memory port.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clr_i = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  logic [7:0] ram [0:65535];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clr_i (clr_i),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM: registered read, data valid the cycle after its address.
  always @(posedge clk) begin
    if (bus.mem_wr_o) ram[bus.mem_a_o[15:0]] <= bus.mem_dout_o;
    bus.mem_din_i <= ram[bus.mem_a_o[15:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    vecs++;
    if ({bus.if_done_o, bus.ls_done_o, bus.mem_wr_o} !== 3'b000) begin
      errs++;
      $display("FAIL reset_ctl got %b exp 000",
               {bus.if_done_o, bus.ls_done_o, bus.mem_wr_o});
    end
    vecs++;
    if (bus.mem_a_o !== 32'h0 || bus.mem_dout_o !== 8'h0) begin
      errs++;
      $display("FAIL reset_mem got a=%h d=%h exp 0", bus.mem_a_o, bus.mem_dout_o);
    end
    vecs++;
    if (bus.if_data_o !== 32'h0 || bus.ls_rdata_o !== 32'h0) begin
      errs++;
      $display("FAIL reset_data got %h %h exp 0", bus.if_data_o, bus.ls_rdata_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_if_read();
    ram[16'h0100] = 8'h13;
    ram[16'h0101] = 8'h05;
    ram[16'h0102] = 8'h00;
    ram[16'h0103] = 8'h00;
    bus.if_addr_i = 32'h100;
    bus.if_req_i  = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n <= 4) begin
        vecs++;
        if (bus.mem_a_o !== 32'h100 + 32'(n - 1)) begin
          errs++;
          $display("FAIL if_addr n=%0d got %h exp %h", n, bus.mem_a_o,
                   32'h100 + 32'(n - 1));
        end
      end
      vecs++;
      if (bus.if_done_o !== (n == 6)) begin
        errs++;
        $display("FAIL if_done n=%0d got %b exp %b", n, bus.if_done_o, n == 6);
      end
      if (n == 6) begin
        vecs++;
        if (bus.if_data_o !== 32'h00000513) begin
          errs++;
          $display("FAIL if_data got %h exp 00000513", bus.if_data_o);
        end
        bus.if_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_sw();
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    bus.ls_addr_i  = 32'h2000;
    bus.ls_wdata_i = wd;
    bus.ls_rw_i    = 1'b1;
    bus.ls_wid_i   = 3'd4;
    bus.ls_req_i   = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n <= 4) begin
        vecs++;
        if ({bus.mem_wr_o, bus.mem_a_o, bus.mem_dout_o} !==
            {1'b1, 32'h2000 + 32'(n - 1), wd[8*(n-1) +: 8]}) begin
          errs++;
          $display("FAIL sw_byte n=%0d got wr=%b a=%h d=%h exp a=%h d=%h", n,
                   bus.mem_wr_o, bus.mem_a_o, bus.mem_dout_o,
                   32'h2000 + 32'(n - 1), wd[8*(n-1) +: 8]);
        end
      end
      vecs++;
      if (bus.ls_done_o !== (n == 5)) begin
        errs++;
        $display("FAIL sw_done n=%0d got %b exp %b", n, bus.ls_done_o, n == 5);
      end
      if (n == 5) bus.ls_req_i = 1'b0;
    end
    vecs++;
    if ({ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]} !== wd) begin
      errs++;
      $display("FAIL sw_ram got %h exp %h",
               {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, wd);
    end
  endtask

  task automatic test_lh();
    ram[16'h0003] = 8'h34;
    ram[16'h0004] = 8'h12;
    bus.ls_addr_i = 32'h3;
    bus.ls_rw_i   = 1'b0;
    bus.ls_wid_i  = 3'd2;
    bus.ls_req_i  = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (n <= 2) begin
        vecs++;
        if (bus.mem_a_o !== 32'h3 + 32'(n - 1) || bus.mem_wr_o !== 1'b0) begin
          errs++;
          $display("FAIL lh_addr n=%0d got %h wr=%b exp %h", n, bus.mem_a_o,
                   bus.mem_wr_o, 32'h3 + 32'(n - 1));
        end
      end
      vecs++;
      if (bus.ls_done_o !== (n == 4)) begin
        errs++;
        $display("FAIL lh_done n=%0d got %b exp %b", n, bus.ls_done_o, n == 4);
      end
      if (n == 4) begin
        vecs++;
        if (bus.ls_rdata_o !== 32'h00001234) begin
          errs++;
          $display("FAIL lh_data got %h exp 00001234", bus.ls_rdata_o);
        end
        bus.ls_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_wrap_width();
    ram[16'hFFFE] = 8'h11;
    ram[16'hFFFF] = 8'h22;
    ram[16'h0000] = 8'h33;
    ram[16'h0001] = 8'h44;
    bus.ls_addr_i = 32'hFFFF_FFFE;
    bus.ls_rw_i   = 1'b0;
    bus.ls_wid_i  = 3'd3;
    bus.ls_req_i  = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 3) begin
        vecs++;
        if (bus.mem_a_o !== 32'h0) begin
          errs++;
          $display("FAIL wrap_addr got %h exp 00000000", bus.mem_a_o);
        end
      end
      vecs++;
      if (bus.ls_done_o !== (n == 6)) begin
        errs++;
        $display("FAIL wid3_done n=%0d got %b exp %b", n, bus.ls_done_o, n == 6);
      end
      if (n == 6) begin
        vecs++;
        if (bus.ls_rdata_o !== 32'h44332211) begin
          errs++;
          $display("FAIL wrap_data got %h exp 44332211", bus.ls_rdata_o);
        end
        bus.ls_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_priority();
    bus.ls_addr_i = 32'h3;
    bus.ls_rw_i   = 1'b0;
    bus.ls_wid_i  = 3'd1;
    bus.ls_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    bus.if_req_i  = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1 || n == 4) begin
        vecs++;
        if (bus.mem_a_o !== ((n == 1) ? 32'h3 : 32'h100)) begin
          errs++;
          $display("FAIL prio_addr n=%0d got %h exp %h", n, bus.mem_a_o,
                   (n == 1) ? 32'h3 : 32'h100);
        end
      end
      vecs++;
      if ({bus.ls_done_o, bus.if_done_o} !== {n == 3, n == 9}) begin
        errs++;
        $display("FAIL prio_done n=%0d got %b%b exp %b%b", n, bus.ls_done_o,
                 bus.if_done_o, n == 3, n == 9);
      end
      if (n == 3) begin
        vecs++;
        if (bus.ls_rdata_o !== 32'h00000034) begin
          errs++;
          $display("FAIL prio_lb got %h exp 00000034", bus.ls_rdata_o);
        end
        bus.ls_req_i = 1'b0;
      end
      if (n == 9) begin
        vecs++;
        if (bus.if_data_o !== 32'h00000513) begin
          errs++;
          $display("FAIL prio_if got %h exp 00000513", bus.if_data_o);
        end
        bus.if_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_clr_if();
    bus.if_addr_i = 32'h100;
    bus.if_req_i  = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n >= 3 && n <= 6) begin
        vecs++;
        if (bus.mem_a_o !== ((n == 3) ? 32'h102 : (n == 6) ? 32'h100 : 32'h0)) begin
          errs++;
          $display("FAIL clr_addr n=%0d got %h", n, bus.mem_a_o);
        end
      end
      vecs++;
      if (bus.if_done_o !== (n == 11)) begin
        errs++;
        $display("FAIL clr_if_done n=%0d got %b exp %b", n, bus.if_done_o, n == 11);
      end
      if (n == 3) clr_i = 1'b1;
      if (n == 5) clr_i = 1'b0;
      if (n == 11) bus.if_req_i = 1'b0;
    end
  endtask

  task automatic test_clr_sw();
    bus.ls_addr_i  = 32'h2100;
    bus.ls_wdata_i = 32'h11223344;
    bus.ls_rw_i    = 1'b1;
    bus.ls_wid_i   = 3'd4;
    bus.ls_req_i   = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n <= 4) begin
        vecs++;
        if (bus.mem_wr_o !== 1'b1 || bus.mem_a_o !== 32'h2100 + 32'(n - 1)) begin
          errs++;
          $display("FAIL clr_sw n=%0d got wr=%b a=%h", n, bus.mem_wr_o, bus.mem_a_o);
        end
      end
      vecs++;
      if (bus.ls_done_o !== (n == 5)) begin
        errs++;
        $display("FAIL clr_sw_done n=%0d got %b exp %b", n, bus.ls_done_o, n == 5);
      end
      if (n == 2) clr_i = 1'b1;
      if (n == 3) clr_i = 1'b0;
      if (n == 5) bus.ls_req_i = 1'b0;
    end
    vecs++;
    if ({ram[16'h2103], ram[16'h2102], ram[16'h2101], ram[16'h2100]} !== 32'h11223344) begin
      errs++;
      $display("FAIL clr_sw_ram got %h exp 11223344",
               {ram[16'h2103], ram[16'h2102], ram[16'h2101], ram[16'h2100]});
    end
  endtask

  task automatic test_rdy_reset();
    ram[16'h2200] = 8'h00;
    ram[16'h2201] = 8'h00;
    bus.ls_addr_i  = 32'h2200;
    bus.ls_wdata_i = 32'h00006677;
    bus.ls_rw_i    = 1'b1;
    bus.ls_wid_i   = 3'd2;
    bus.ls_req_i   = 1'b1;
    tick();
    vecs++;
    if (bus.mem_wr_o !== 1'b1 || bus.mem_a_o !== 32'h2200) begin
      errs++;
      $display("FAIL rdy_start got wr=%b a=%h", bus.mem_wr_o, bus.mem_a_o);
    end
    rdy = 1'b0;
    #1;
    vecs++;
    if (bus.mem_wr_o !== 1'b0) begin
      errs++;
      $display("FAIL rdy_wr_gate got %b exp 0", bus.mem_wr_o);
    end
    for (int n = 2; n <= 4; n++) begin
      tick();
      vecs++;
      if (bus.mem_wr_o !== 1'b0 || bus.mem_a_o !== 32'h2200) begin
        errs++;
        $display("FAIL rdy_frozen n=%0d got wr=%b a=%h", n, bus.mem_wr_o, bus.mem_a_o);
      end
    end
    rdy = 1'b1;
    tick();
    vecs++;
    if (bus.mem_wr_o !== 1'b1 || bus.mem_a_o !== 32'h2201) begin
      errs++;
      $display("FAIL rdy_resume got wr=%b a=%h exp 1 2201", bus.mem_wr_o, bus.mem_a_o);
    end
    rst = 1'b0;
    bus.ls_req_i = 1'b0;
    #1;
    vecs++;
    if ({bus.mem_wr_o, bus.ls_done_o} !== 2'b00 || bus.mem_a_o !== 32'h0) begin
      errs++;
      $display("FAIL mid_reset got wr=%b done=%b a=%h", bus.mem_wr_o,
               bus.ls_done_o, bus.mem_a_o);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    vecs++;
    if (bus.ls_rdata_o !== 32'h0 || bus.if_data_o !== 32'h0 ||
        {bus.ls_done_o, bus.if_done_o} !== 2'b00) begin
      errs++;
      $display("FAIL post_reset got ls=%h if=%h", bus.ls_rdata_o, bus.if_data_o);
    end
    vecs++;
    if (ram[16'h2200] !== 8'h77 || ram[16'h2201] !== 8'h00) begin
      errs++;
      $display("FAIL rdy_ram got %h %h exp 77 00", ram[16'h2200], ram[16'h2201]);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.ls_req_i   = 1'b0;
    bus.ls_rw_i    = 1'b0;
    bus.ls_wid_i   = 3'd0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
    bus.mem_din_i  = 8'h00;
    test_reset();
    test_if_read();
    test_sw();
    test_lh();
    test_wrap_width();
    test_priority();
    test_clr_if();
    test_clr_sw();
    test_rdy_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vecs);
    $fatal(1, "timeout");
  end

endmodule
